// File: rtl/level_detector.sv
// Hysteresis level detector with hold-off persistence, threshold sanity flag and saturating rise counter.
// Latency: 1 clk from the last qualifying sample to level/rise/fall; no backpressure, samples are qualified by ena.
module level_detector #(
  parameter int DATA_W = 32,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] id,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic [HOLD_W-1:0] hold,
  input  logic              cnt_clr,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic              thr_err,
  output logic [15:0]       events
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_PEND_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_PEND_LO = 2'd3
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] lim;
  logic              hi_q;
  logic              lo_q;
  logic              go_hi;
  logic              go_lo;
  logic [15:0]       events_nxt;

  assign hi_q = (id >= thr_hi);
  assign lo_q = (id <= thr_lo);

  // Transition strobes, shared by the pulse registers and the event counter.
  assign go_hi = !thr_err && ena && hi_q &&
                 (((state == S_LOW) && (hold == '0)) || ((state == S_PEND_HI) && (cnt == lim)));
  assign go_lo = !thr_err && ena && lo_q &&
                 (((state == S_HIGH) && (hold == '0)) || ((state == S_PEND_LO) && (cnt == lim)));

  always_comb begin
    events_nxt = events;
    if (cnt_clr)
      events_nxt = {15'd0, go_hi};
    else if (go_hi && (events != 16'hFFFF))
      events_nxt = events + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOW;
      cnt     <= '0;
      lim     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      thr_err <= 1'b0;
      events  <= 16'd0;
    end else begin
      thr_err <= (thr_lo >= thr_hi);
      rise    <= go_hi;
      fall    <= go_lo;
      events  <= events_nxt;
      if (thr_err) begin
        // Inconsistent thresholds: abandon any pending qualification, keep the settled level.
        cnt <= '0;
        if (state == S_PEND_HI) state <= S_LOW;
        if (state == S_PEND_LO) state <= S_HIGH;
      end else if (ena) begin
        case (state)
          S_LOW: begin
            if (hi_q) begin
              if (hold == '0) begin
                state <= S_HIGH;
                level <= 1'b1;
              end else begin
                state <= S_PEND_HI;
                cnt   <= HOLD_W'(1);
                lim   <= hold;
              end
            end
          end
          S_PEND_HI: begin
            if (!hi_q) begin
              state <= S_LOW;
              cnt   <= '0;
            end else if (cnt == lim) begin
              state <= S_HIGH;
              cnt   <= '0;
              level <= 1'b1;
            end else begin
              cnt <= cnt + HOLD_W'(1);
            end
          end
          S_HIGH: begin
            if (lo_q) begin
              if (hold == '0) begin
                state <= S_LOW;
                level <= 1'b0;
              end else begin
                state <= S_PEND_LO;
                cnt   <= HOLD_W'(1);
                lim   <= hold;
              end
            end
          end
          S_PEND_LO: begin
            if (!lo_q) begin
              state <= S_HIGH;
              cnt   <= '0;
            end else if (cnt == lim) begin
              state <= S_LOW;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              cnt <= cnt + HOLD_W'(1);
            end
          end
          default: begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_level_detector.sv
// Randomised and directed bench for level_detector against a run-length reference model.
module tb_level_detector;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [31:0] id;
  logic [31:0] thr_hi;
  logic [31:0] thr_lo;
  logic [7:0]  hold;
  logic        cnt_clr;
  logic        level;
  logic        rise;
  logic        fall;
  logic        thr_err;
  logic [15:0] events;

  int n_vec;
  int n_err;

  level_detector dut (
    .clk(clk), .rst(rst), .ena(ena), .id(id), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .hold(hold), .cnt_clr(cnt_clr), .level(level), .rise(rise), .fall(fall),
    .thr_err(thr_err), .events(events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count consecutive qualifying samples toward the opposite level,
  // flip once the count reaches hold+1 (hold captured when the run starts).
  int          run_m;
  int          need_m;
  bit          lvl_m;
  bit          rise_m;
  bit          fall_m;
  bit          err_m;
  logic [15:0] ev_m;
  bit          ev_load;
  bit          toward;
  bit          flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_m  = 0;
      need_m = 0;
      lvl_m  = 0;
      rise_m = 0;
      fall_m = 0;
      err_m  = 0;
      ev_m   = 16'd0;
    end else begin
      flip = 0;
      if (err_m) begin
        run_m = 0;
      end else if (ena) begin
        toward = lvl_m ? (id <= thr_lo) : (id >= thr_hi);
        if (toward) begin
          if (run_m == 0) need_m = int'(hold) + 1;
          run_m++;
          if (run_m == need_m) begin
            flip  = 1;
            run_m = 0;
          end
        end else begin
          run_m = 0;
        end
      end
      rise_m = flip && !lvl_m;
      fall_m = flip && lvl_m;
      if (flip) lvl_m = !lvl_m;
      if (ev_load) ev_m = 16'hFFFE;
      if (cnt_clr) ev_m = rise_m ? 16'd1 : 16'd0;
      else if (rise_m && ev_m != 16'hFFFF) ev_m = ev_m + 16'd1;
      err_m = (thr_lo >= thr_hi);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cycle();
    @(negedge clk);
    chk("level", level, lvl_m);
    chk("rise", rise, rise_m);
    chk("fall", fall, fall_m);
    chk("thr_err", thr_err, err_m);
    chk("events", events, ev_m);
  endtask

  task automatic sample(input logic [31:0] v);
    ena = 1'b1;
    id  = v;
    cycle();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    ev_load = 0;
    rst     = 1'b1;
    ena     = 1'b0;
    id      = 0;
    thr_hi  = 100;
    thr_lo  = 50;
    hold    = 0;
    cnt_clr = 1'b0;
    #12;
    chk("rst_level", level, 1'b0);
    chk("rst_rise", rise, 1'b0);
    chk("rst_fall", fall, 1'b0);
    chk("rst_thr_err", thr_err, 1'b0);
    chk("rst_events", events, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Immediate rise with hold=0.
    sample(0);
    sample(120);
    chk("d_rise", rise, 1'b1);
    chk("d_level", level, 1'b1);
    chk("d_events", events, 16'd1);
    sample(120);
    chk("d_rise_once", rise, 1'b0);
    sample(40);
    chk("d_fall", fall, 1'b1);
    chk("d_level_lo", level, 1'b0);

    // hold=3: interrupted run aborts, four clean samples qualify.
    hold = 3;
    sample(120); sample(120); sample(120); sample(40);
    chk("h3_abort_level", level, 1'b0);
    sample(120); sample(120); sample(120);
    chk("h3_early_rise", rise, 1'b0);
    sample(120);
    chk("h3_rise", rise, 1'b1);
    hold = 0;
    sample(40);

    // hold=2 with ena gaps.
    hold = 2;
    sample(120);
    ena = 1'b0; cycle();
    sample(120);
    ena = 1'b0; cycle();
    chk("gap_no_rise", level, 1'b0);
    sample(120);
    chk("gap_rise", rise, 1'b1);
    hold = 0;
    sample(40);

    // Maximum hold: 256 consecutive samples required.
    hold = 8'hFF;
    for (int i = 0; i < 255; i++) sample(120);
    chk("hmax_early", level, 1'b0);
    sample(120);
    chk("hmax_rise", rise, 1'b1);
    hold = 0;
    sample(40);

    // Equal thresholds: error flag and a quiet sweep.
    thr_hi = 50;
    thr_lo = 50;
    ena = 1'b0;
    cycle();
    chk("err_flag", thr_err, 1'b1);
    for (int v = 0; v < 256; v++) begin
      sample(v);
      chk("err_no_rise", rise, 1'b0);
      chk("err_no_fall", fall, 1'b0);
    end
    thr_hi = 100;
    sample(0);
    sample(0);

    // Saturation and clear-with-rise.
    ena = 1'b0;
    force dut.events = 16'hFFFE;
    ev_load = 1;
    cycle();
    release dut.events;
    ev_load = 0;
    cycle();
    chk("sat_load", events, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      sample(120);
      sample(40);
    end
    chk("sat_events", events, 16'hFFFF);
    cnt_clr = 1'b1;
    sample(120);
    cnt_clr = 1'b0;
    chk("clr_rise_events", events, 16'd1);

    // Asynchronous reset while HIGH.
    ena = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", level, 1'b0);
    chk("arst_events", events, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    sample(120);
    chk("arst_rise", rise, 1'b1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      ena     = ($urandom_range(3) != 0);
      id      = $urandom_range(150);
      cnt_clr = ($urandom_range(31) == 0);
      if ($urandom_range(7) == 0) hold = 8'($urandom_range(4));
      if ($urandom_range(99) == 0) thr_lo = $urandom_range(40, 110);
      if ($urandom_range(99) == 0) thr_lo = 50;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/level_detector.md
LEVEL_DETECTOR -- requirements
Module: level_detector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the input sample and thresholds.
REQ-002 SHALL have parameter HOLD_W, default 8, width of the persistence count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port ena  input  1  sample-valid qualifier; id is evaluated only when ena=1.
REQ-006 SHALL have port id  input  DATA_W  unsigned sample, e.g. the moving-average output.
REQ-007 SHALL have port thr_hi  input  DATA_W  unsigned rising threshold.
REQ-008 SHALL have port thr_lo  input  DATA_W  unsigned falling threshold.
REQ-009 SHALL have port hold  input  HOLD_W  extra consecutive qualifying samples required before a level change.
REQ-010 SHALL have port cnt_clr  input  1  synchronous clear of the event counter.
REQ-011 SHALL have port level  output  1  registered detected level.
REQ-012 SHALL have port rise  output  1  one-cycle pulse on each LOW->HIGH change.
REQ-013 SHALL have port fall  output  1  one-cycle pulse on each HIGH->LOW change.
REQ-014 SHALL have port thr_err  output  1  registered flag, thr_lo >= thr_hi.
REQ-015 SHALL have port events  output  16  saturating count of rise pulses.

Function
REQ-016 SHALL implement an FSM with the states LOW, PEND_HI, HIGH and PEND_LO, plus an HOLD_W-bit persistence counter cnt and an HOLD_W-bit latched limit lim.
REQ-017 SHALL use only unsigned comparisons: "hi-qualify" = id >= thr_hi; "lo-qualify" = id <= thr_lo.
REQ-018 SHALL hold the state, cnt and lim unchanged in any cycle with ena=0.
REQ-019 In LOW with ena=1 and hi-qualify, SHALL go to HIGH if hold=0, otherwise to PEND_HI with cnt=1 and lim=hold.
REQ-020 In PEND_HI with ena=1 and hi-qualify, SHALL go to HIGH if cnt==lim, otherwise increment cnt.
REQ-021 In PEND_HI with ena=1 and not hi-qualify, SHALL return to LOW with cnt=0 and no pulse.
REQ-022 SHALL handle HIGH/PEND_LO symmetrically using lo-qualify, and SHALL return from PEND_LO to HIGH when a non-qualifying sample arrives.
REQ-023 SHALL latch lim only on entry to a PEND state; a change of hold during PEND SHALL have no effect until the next entry.
REQ-024 SHALL drive level=1 in HIGH and PEND_LO, and level=0 in LOW and PEND_HI.
REQ-025 SHALL assert rise (fall) for exactly one cycle, in the cycle after the edge on which the state enters HIGH (LOW) from the opposite side; latency from the last qualifying sample to level/rise is 1 clk.
REQ-026 SHALL make thr_err = (thr_lo >= thr_hi), registered, with 1 clk latency.
REQ-027 While thr_err=1, SHALL perform no transitions, clear cnt to 0, and force a PEND state back to its stable state (PEND_HI->LOW, PEND_LO->HIGH) with no pulse.
REQ-028 SHALL increment events on each rise pulse and saturate it at 16'hFFFF with no wrap.
REQ-029 SHALL clear events to 0 on cnt_clr=1; if a rise pulse occurs in the same cycle, events SHALL become 1.
REQ-030 SHALL accept hold at its maximum value (all ones); qualification then requires 2^HOLD_W consecutive qualifying samples.

Reset
REQ-031 rst=1 SHALL immediately force state=LOW, cnt=0, lim=0, level=0, rise=0, fall=0, thr_err=0 and events=0, regardless of clk.
REQ-032 Assertion of rst mid-PEND or mid-pulse SHALL discard the pending qualification; the first sample after rst deasserts SHALL be evaluated from LOW.

Verification
REQ-033 With thr_hi=100, thr_lo=50, hold=0, ena=1, id 0->120: rise=1 and level=1 one clk after the first 120 sample; events=1.
REQ-034 With hold=3 and the hi sequence 120,120,120,40: no rise, state returns to LOW; then four consecutive 120 samples: rise after the 4th sample.
REQ-035 With hold=2, PEND_HI, ena toggling 1,0,1,0,1 with id=120 each ena cycle: rise only after the 3rd ena=1 sample.
REQ-036 With thr_hi=50 and thr_lo=50: thr_err=1 one clk later; id sweeping 0..255 produces no rise/fall.
REQ-037 With events forced to 16'hFFFE, three rise events: events ends at 16'hFFFF; cnt_clr coincident with a rise gives events=1.
REQ-038 rst asserted asynchronously between clk edges while in HIGH: level=0 before the next clk edge; afterwards, id=120 with hold=0 gives rise again.
